// File: rtl/instr_fetch.sv
// Instruction fetch: PC sequencer, 1-cycle memory latency absorption via a 2-entry skid buffer,
// valid/ready delivery to decode, redirect flush. Optional counters under IFETCH_PERF_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_o,
  input  logic [31:0] instr_i,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_redirects
`endif
);

  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  entry_t      head_q, head_d;
  entry_t      tail_q, tail_d;

  logic        pop;
  logic        issue;
  logic [1:0]  occ;
  entry_t      new_e;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;

    pop   = head_q.v & if_ready;
    // Occupancy after this cycle's pop, counting the fetch whose data arrives next edge.
    occ   = {1'b0, head_q.v} + {1'b0, tail_q.v} + {1'b0, inflight_q} - {1'b0, pop};
    issue = !redirect_valid && (occ <= 2'd1);
    new_e = '{v: 1'b1, pc: inflight_pc_q, instr: instr_i};

    if (redirect_valid) begin
      pc_d     = redirect_pc & ADDR_MASK & ~32'h3;
      head_d.v = 1'b0;
      tail_d.v = 1'b0;
    end else begin
      if (issue) begin
        pc_d          = (pc_q + 32'd4) & ADDR_MASK;
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
      end
      if (pop) begin
        head_d   = tail_q;
        tail_d.v = 1'b0;
      end
      if (inflight_q) begin
        if (!head_d.v) head_d = new_e;
        else           tail_d = new_e;
      end
    end
  end

  // Reset is active-high despite the rst_n name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      // NOTE: buffer payloads are reset too, because the head payload drives if_pc/if_instr directly.
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
    end
  end

  assign pc_o     = pc_q;
  assign if_valid = head_q.v;
  assign if_pc    = head_q.pc;
  assign if_instr = head_q.instr;

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetches_q, perf_fetches_d;
  logic [31:0] perf_redirects_q, perf_redirects_d;

  // Every capture counts, including ones a redirect flushes in the same edge.
  always_comb begin
    perf_fetches_d   = perf_fetches_q + {31'h0, inflight_q};
    perf_redirects_d = perf_redirects_q + {31'h0, redirect_valid};
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      perf_fetches_q   <= 32'h0;
      perf_redirects_q <= 32'h0;
    end else begin
      perf_fetches_q   <= perf_fetches_d;
      perf_redirects_q <= perf_redirects_d;
    end
  end

  assign perf_fetches   = perf_fetches_q;
  assign perf_redirects = perf_redirects_q;
`endif

endmodule
